// File: rtl/imem_pkg.sv
// Purpose : shared state encoding, alignment mask and default sizing for the I-side miss handler.
// Latency : n/a (type and constant definitions only).
// Backpressure: n/a.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        BACKOFF = 2'd2,
        FILL    = 2'd3
    } miss_state_t;

    localparam logic [31:0] WORD_ALIGN  = 32'hFFFF_FFFC;
    localparam int          TIMEOUT_DEF = 16;
    localparam int          CNT_W_DEF   = 20;

endpackage

// File: rtl/sat_counter.sv
// Purpose : W-bit statistics counter that sticks at all-ones instead of wrapping.
// Latency : value reflects an increment one edge after inc is seen.
// Backpressure: none; inc is sampled every cycle.
//
// Ports: CLK/RESET (async, active-high), inc (count enable), cnt (current value).
module sat_counter #(
    parameter int W = 20
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/imem_miss_ctrl.sv
// Purpose : I-cache miss handler; fetches the stalled PC's word from memory and fills the cache.
// Latency : miss seen -> MEM_REQ 1 cycle; MEM_ACK -> Access_MM 1 cycle; zero-wait miss-to-hit 4 cycles.
// Backpressure: waits on MEM_ACK; withdraws and reissues after TIMEOUT unacknowledged cycles.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   PC, HitWrite        fetch PC and cache registered hit flag (0 = miss / stalled)
//   Access_MM, Data_MM  one-cycle fill strobe and fill data to the cache
//   MEM_REQ, MEM_ADDR   memory read request and word-aligned address
//   MEM_ACK, MEM_RDATA  memory acknowledge with same-cycle read data
//   Busy                state is not IDLE
//   CNT_*               saturating statistics: fills, stall cycles, timeouts, dropped fetches
module imem_miss_ctrl
    import imem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      PC,
    input  logic             HitWrite,
    output logic             Access_MM,
    output logic [31:0]      Data_MM,
    output logic             MEM_REQ,
    output logic [31:0]      MEM_ADDR,
    input  logic             MEM_ACK,
    input  logic [31:0]      MEM_RDATA,
    output logic             Busy,
    output logic [CNT_W-1:0] CNT_FETCH,
    output logic [CNT_W-1:0] CNT_STALL,
    output logic [CNT_W-1:0] CNT_RETRY,
    output logic [CNT_W-1:0] CNT_DROP
);

    localparam int              TO_W    = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    miss_state_t     state, state_nxt;
    logic [TO_W-1:0] tcnt, tcnt_nxt;
    logic            req_nxt;
    logic            acc_nxt;
    logic [31:0]     data_nxt;
    logic [31:0]     addr_nxt;
    logic            pc_match;
    logic            retry_inc;
    logic            drop_inc;

    // The cache compares tags against the live PC, so a fetch is only useful
    // if the PC still names the word we asked for when the data comes back.
    assign pc_match = ((PC & WORD_ALIGN) == MEM_ADDR);
    assign Busy     = (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            tcnt      <= '0;
            MEM_REQ   <= 1'b0;
            MEM_ADDR  <= '0;
            Access_MM <= 1'b0;
            Data_MM   <= '0;
        end else begin
            state     <= state_nxt;
            tcnt      <= tcnt_nxt;
            MEM_REQ   <= req_nxt;
            MEM_ADDR  <= addr_nxt;
            Access_MM <= acc_nxt;
            Data_MM   <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        req_nxt   = MEM_REQ;
        acc_nxt   = 1'b0;
        data_nxt  = Data_MM;
        addr_nxt  = MEM_ADDR;
        retry_inc = 1'b0;
        drop_inc  = 1'b0;

        case (state)
            IDLE: begin
                if (!HitWrite) begin
                    addr_nxt  = PC & WORD_ALIGN;
                    req_nxt   = 1'b1;
                    tcnt_nxt  = '0;
                    state_nxt = REQ;
                end
            end

            REQ: begin
                // Ack is checked before the timeout so a coincident ack is never retried.
                if (MEM_ACK) begin
                    req_nxt = 1'b0;
                    if (pc_match) begin
                        data_nxt  = MEM_RDATA;
                        acc_nxt   = 1'b1;
                        state_nxt = FILL;
                    end else begin
                        drop_inc  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tcnt == TO_LAST) begin
                    req_nxt   = 1'b0;
                    retry_inc = 1'b1;
                    state_nxt = BACKOFF;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end

            // Reissue the latched address; PC is deliberately not re-sampled here.
            BACKOFF: begin
                req_nxt   = 1'b1;
                tcnt_nxt  = '0;
                state_nxt = REQ;
            end

            FILL: begin
                state_nxt = IDLE;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_cnt_fetch (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (state == FILL),
        .cnt   (CNT_FETCH)
    );

    sat_counter #(.W(CNT_W)) u_cnt_stall (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (Busy),
        .cnt   (CNT_STALL)
    );

    sat_counter #(.W(CNT_W)) u_cnt_retry (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (retry_inc),
        .cnt   (CNT_RETRY)
    );

    sat_counter #(.W(CNT_W)) u_cnt_drop (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (drop_inc),
        .cnt   (CNT_DROP)
    );

endmodule

// File: tb/tb_imem_miss_ctrl.sv
// Purpose : directed self-checking bench for imem_miss_ctrl (TIMEOUT=4, CNT_W=4).
// Latency : inputs change 1ns after a rising edge; outputs are sampled 1ns after the edge.
// Backpressure: memory acks are driven directly by the directed steps.
module tb_imem_miss_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   PC;
    logic          HitWrite;
    logic          Access_MM;
    logic [31:0]   Data_MM;
    logic          MEM_REQ;
    logic [31:0]   MEM_ADDR;
    logic          MEM_ACK;
    logic [31:0]   MEM_RDATA;
    logic          Busy;
    logic [CW-1:0] CNT_FETCH;
    logic [CW-1:0] CNT_STALL;
    logic [CW-1:0] CNT_RETRY;
    logic [CW-1:0] CNT_DROP;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    imem_miss_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PC        (PC),
        .HitWrite  (HitWrite),
        .Access_MM (Access_MM),
        .Data_MM   (Data_MM),
        .MEM_REQ   (MEM_REQ),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_ACK   (MEM_ACK),
        .MEM_RDATA (MEM_RDATA),
        .Busy      (Busy),
        .CNT_FETCH (CNT_FETCH),
        .CNT_STALL (CNT_STALL),
        .CNT_RETRY (CNT_RETRY),
        .CNT_DROP  (CNT_DROP)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET     = 1'b1;
        PC        = 32'h0000_0040;
        HitWrite  = 1'b1;
        MEM_ACK   = 1'b0;
        MEM_RDATA = 32'h0;
        #12;

        // ---- reset state ----
        chk("rst_req",   {31'd0, MEM_REQ},   32'd0);
        chk("rst_acc",   {31'd0, Access_MM}, 32'd0);
        chk("rst_addr",  MEM_ADDR,           32'd0);
        chk("rst_data",  Data_MM,            32'd0);
        chk("rst_busy",  {31'd0, Busy},      32'd0);
        chk("rst_fetch", 32'(CNT_FETCH),     32'd0);

        // ---- basic miss, ack one cycle after REQ ----
        RESET    = 1'b0;
        HitWrite = 1'b0;
        step();
        chk("t1_req",  {31'd0, MEM_REQ}, 32'd1);
        chk("t1_addr", MEM_ADDR,         32'h0000_0040);
        chk("t1_busy", {31'd0, Busy},    32'd1);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h2008_0005;
        step();
        chk("t1_acc",     {31'd0, Access_MM}, 32'd1);
        chk("t1_data",    Data_MM,            32'h2008_0005);
        chk("t1_req_low", {31'd0, MEM_REQ},   32'd0);
        MEM_ACK   = 1'b0;
        MEM_RDATA = 32'h0;
        HitWrite  = 1'b1;
        step();
        chk("t1_acc_off",   {31'd0, Access_MM}, 32'd0);
        chk("t1_data_hold", Data_MM,            32'h2008_0005);
        chk("t1_fetch",     32'(CNT_FETCH),     32'd1);
        chk("t1_stall",     32'(CNT_STALL),     32'd2);
        chk("t1_idle",      {31'd0, Busy},      32'd0);
        step();
        chk("t1_stay_idle", {31'd0, MEM_REQ},   32'd0);

        // ---- no ack: timeout, backoff, reissue ----
        HitWrite = 1'b0;
        for (int i = 0; i < TO; i++) begin
            step();
            chk($sformatf("t2_req_hi%0d", i), {31'd0, MEM_REQ}, 32'd1);
            chk($sformatf("t2_addr%0d", i),   MEM_ADDR,         32'h0000_0040);
        end
        step();
        chk("t2_backoff_req", {31'd0, MEM_REQ}, 32'd0);
        chk("t2_retry",       32'(CNT_RETRY),   32'd1);
        chk("t2_backoff_bsy", {31'd0, Busy},    32'd1);
        step();
        chk("t2_reissue_req",  {31'd0, MEM_REQ}, 32'd1);
        chk("t2_reissue_addr", MEM_ADDR,         32'h0000_0040);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h1234_5678;
        step();
        chk("t2_acc",  {31'd0, Access_MM}, 32'd1);
        chk("t2_data", Data_MM,            32'h1234_5678);
        MEM_ACK  = 1'b0;
        HitWrite = 1'b1;
        step();
        chk("t2_acc_off", {31'd0, Access_MM}, 32'd0);
        chk("t2_fetch",   32'(CNT_FETCH),     32'd2);
        chk("t2_retry2",  32'(CNT_RETRY),     32'd1);
        chk("t2_stall",   32'(CNT_STALL),     32'd9);

        // ---- PC moves during REQ: data dropped ----
        HitWrite = 1'b0;
        step();
        chk("t3_addr", MEM_ADDR, 32'h0000_0040);
        PC = 32'h0000_0080;
        step();
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'hDEAD_BEEF;
        step();
        chk("t3_no_acc", {31'd0, Access_MM}, 32'd0);
        chk("t3_drop",   32'(CNT_DROP),      32'd1);
        chk("t3_idle",   {31'd0, Busy},      32'd0);
        chk("t3_fetch",  32'(CNT_FETCH),     32'd2);
        MEM_ACK = 1'b0;
        step();
        chk("t3_new_req",  {31'd0, MEM_REQ}, 32'd1);
        chk("t3_new_addr", MEM_ADDR,         32'h0000_0080);

        // ---- async reset while MEM_REQ is high ----
        #2;
        RESET = 1'b1;
        #1;
        chk("t4_req",   {31'd0, MEM_REQ},   32'd0);
        chk("t4_acc",   {31'd0, Access_MM}, 32'd0);
        chk("t4_busy",  {31'd0, Busy},      32'd0);
        chk("t4_fetch", 32'(CNT_FETCH),     32'd0);
        chk("t4_stall", 32'(CNT_STALL),     32'd0);
        chk("t4_drop",  32'(CNT_DROP),      32'd0);
        #1;
        RESET     = 1'b0;
        HitWrite  = 1'b1;
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h5555_AAAA;
        step();
        chk("t4_late_ack_acc",  {31'd0, Access_MM}, 32'd0);
        chk("t4_late_ack_busy", {31'd0, Busy},      32'd0);
        chk("t4_late_ack_data", Data_MM,            32'd0);
        MEM_ACK = 1'b0;

        // ---- ack coincident with timeout expiry ----
        PC       = 32'h0000_0040;
        HitWrite = 1'b0;
        for (int i = 0; i < TO; i++) begin
            step();
        end
        chk("t5_req_last", {31'd0, MEM_REQ}, 32'd1);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'hCAFE_0001;
        step();
        chk("t5_acc",   {31'd0, Access_MM}, 32'd1);
        chk("t5_data",  Data_MM,            32'hCAFE_0001);
        chk("t5_retry", 32'(CNT_RETRY),     32'd0);
        MEM_ACK  = 1'b0;
        HitWrite = 1'b1;
        step();
        chk("t5_fetch",  32'(CNT_FETCH), 32'd1);
        chk("t5_retry2", 32'(CNT_RETRY), 32'd0);
        chk("t5_stall",  32'(CNT_STALL), 32'd5);

        // ---- 16 back-to-back zero-wait misses: counters saturate ----
        #2;
        RESET = 1'b1;
        #2;
        RESET     = 1'b0;
        HitWrite  = 1'b0;
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h0000_0F0F;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        chk("t6_fetch1", 32'(CNT_FETCH), 32'd1);
        chk("t6_stall1", 32'(CNT_STALL), 32'd2);
        for (int i = 0; i < 42; i++) begin
            step();
        end
        chk("t6_fetch15", 32'(CNT_FETCH), 32'hF);
        chk("t6_stall30", 32'(CNT_STALL), 32'hF);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        HitWrite = 1'b1;
        MEM_ACK  = 1'b0;
        chk("t6_fetch_sat", 32'(CNT_FETCH), 32'hF);
        chk("t6_stall_sat", 32'(CNT_STALL), 32'hF);
        chk("t6_busy",      {31'd0, Busy},  32'd0);
        step();
        chk("t6_idle_hold", {31'd0, Busy},  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
